// File: rtl/irq_pkg.sv
`default_nettype none
//==============================================================================
// Module      : irq_pkg
// Description : Shared register map, claim ID width and interrupt bit indices
//               for the interrupt/timer controller.
// Revision    : 1.0 - initial release
//==============================================================================
package irq_pkg;

    localparam logic [4:0] MTIME_LO    = 5'h00;
    localparam logic [4:0] MTIME_HI    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO = 5'h08;
    localparam logic [4:0] MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] PENDING     = 5'h10;
    localparam logic [4:0] ENABLE      = 5'h14;
    localparam logic [4:0] CLAIM       = 5'h18;
    localparam logic [4:0] TYPE        = 5'h1C;

    localparam int ID_W    = 5;
    localparam int IRQ_EXT = 0;
    localparam int IRQ_TMR = 1;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
//==============================================================================
// Module      : irq_prio_enc
// Description : Lowest-index-first priority encoder; ID is index + 1, 0 if none.
// Revision    : 1.0 - initial release
//==============================================================================
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]    i_req,
    output logic            o_valid,
    output logic [ID_W-1:0] o_id
);

    // Scanning downwards lets the lowest set index overwrite any higher one.
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_id    = ID_W'(i + 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_timer_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : irq_timer_ctrl
// Description : Memory-mapped 64-bit machine timer plus external interrupt
//               aggregator with enable/pending/claim/complete.
// Revision    : 1.0 - initial release
//==============================================================================
module irq_timer_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC  = 8,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cs,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [4:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic [NUM_SRC-1:0] ext_irq,
    output logic [1:0]         interrupt
);

    localparam int c_ps_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [c_ps_w-1:0]  r_presc;
    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp;
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_in_service;
    logic [NUM_SRC-1:0] r_type;
    logic [1:0]         r_irq;

    logic [4:0]         w_reg;
    logic               w_wr;
    logic               w_rd;
    logic               w_tick;
    logic               w_claim;
    logic               w_complete;
    logic               w_claim_valid;
    logic [ID_W-1:0]    w_claim_id;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_active;
    logic [NUM_SRC-1:0] w_claim_set;
    logic [NUM_SRC-1:0] w_cmp_clr;
    logic [NUM_SRC-1:0] w_pend_next;

    // A simultaneous read and write counts only as the write.
    assign w_reg      = addr & 5'b11100;
    assign w_wr       = cs & wr_en;
    assign w_rd       = cs & rd_en & ~wr_en;
    assign w_tick     = (r_presc == c_ps_w'(PRESCALE - 1));
    assign w_rise     = r_sync2 & ~r_prev;
    assign w_active   = r_pending & r_enable & ~r_in_service;
    assign w_claim    = w_rd && (w_reg == CLAIM) && w_claim_valid;
    assign w_complete = w_wr && (w_reg == CLAIM);

    irq_prio_enc #(
        .N(NUM_SRC)
    ) u_prio_enc (
        .i_req  (w_active),
        .o_valid(w_claim_valid),
        .o_id   (w_claim_id)
    );

    // Per-source decode; IDs 0 or above NUM_SRC match no source and are ignored.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign w_claim_set[i] = w_claim && (w_claim_id == ID_W'(i + 1));
        assign w_cmp_clr[i]   = w_complete && (wdata[ID_W-1:0] == ID_W'(i + 1));
        assign w_pend_next[i] = r_type[i] ? (w_rise[i] | (r_pending[i] & ~w_claim_set[i]))
                                          : r_sync2[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc    <= '0;
            r_mtime    <= '0;
            r_mtimecmp <= '1;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_ps_w'(1);
            if (w_wr && (w_reg == MTIME_LO)) begin
                r_mtime[31:0] <= wdata;
            end else if (w_wr && (w_reg == MTIME_HI)) begin
                r_mtime[63:32] <= wdata;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end
            if (w_wr && (w_reg == MTIMECMP_LO)) r_mtimecmp[31:0]  <= wdata;
            if (w_wr && (w_reg == MTIMECMP_HI)) r_mtimecmp[63:32] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_prev       <= '0;
            r_pending    <= '0;
            r_enable     <= '0;
            r_in_service <= '0;
            r_type       <= '0;
            r_irq        <= 2'b00;
        end else begin
            r_sync1      <= ext_irq;
            r_sync2      <= r_sync1;
            r_prev       <= r_sync2;
            r_pending    <= w_pend_next;
            r_in_service <= (r_in_service | w_claim_set) & ~w_cmp_clr;
            if (w_wr && (w_reg == ENABLE)) r_enable <= wdata[NUM_SRC-1:0];
            if (w_wr && (w_reg == TYPE))   r_type   <= wdata[NUM_SRC-1:0];
            r_irq[IRQ_EXT] <= |w_active;
            r_irq[IRQ_TMR] <= (r_mtime >= r_mtimecmp);
        end
    end

    assign interrupt = r_irq;

    always_comb begin
        rdata = '0;
        if (cs) begin
            case (w_reg)
                MTIME_LO:    rdata = r_mtime[31:0];
                MTIME_HI:    rdata = r_mtime[63:32];
                MTIMECMP_LO: rdata = r_mtimecmp[31:0];
                MTIMECMP_HI: rdata = r_mtimecmp[63:32];
                PENDING:     rdata = 32'(r_pending);
                ENABLE:      rdata = 32'(r_enable);
                CLAIM:       rdata = 32'(w_claim_id);
                TYPE:        rdata = 32'(r_type);
                default:     rdata = '0;
            endcase
        end
    end

endmodule
`default_nettype wire
